// File: rtl/lbctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : lbctrl_pkg
// Brief   : Shared state encoding, frame size limits and size check for the
//           line buffer scan controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lbctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } lbctrl_state_t;

    localparam int unsigned MAX_DIM = 416;
    localparam int unsigned MIN_ROW = 4;
    localparam int unsigned MIN_COL = 2;

    function automatic logic size_ok(input int unsigned rows, input int unsigned cols);
        return (rows >= MIN_ROW) && (rows <= MAX_DIM) &&
               (cols >= MIN_COL) && (cols <= MAX_DIM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbctrl_scan_cnt.sv
//------------------------------------------------------------------------------
// Module  : lbctrl_scan_cnt
// Brief   : 2-D slot counter (row fastest) with latched bounds and
//           last-input / last-slot flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbctrl_scan_cnt
    import lbctrl_pkg::*;
#(
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   load,
    input  logic                   en,
    input  logic [MaxRowWidth-1:0] row_size,
    input  logic [MaxColWidth-1:0] col_size,
    output logic [MaxRowWidth-1:0] row,
    output logic [MaxColWidth-1:0] col,
    output logic                   last_input,
    output logic                   last_slot
);

    localparam logic [MaxRowWidth-1:0] c_row_one = MaxRowWidth'(1);
    localparam logic [MaxColWidth-1:0] c_col_one = MaxColWidth'(1);

    logic [MaxRowWidth-1:0] r_row_size;
    logic [MaxColWidth-1:0] r_col_size;
    logic [MaxRowWidth-1:0] r_row;
    logic [MaxColWidth-1:0] r_col;
    logic                   w_row_wrap;

    assign w_row_wrap = (r_row == r_row_size - c_row_one);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_row_size <= '0;
            r_col_size <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else if (load) begin
            r_row_size <= row_size;
            r_col_size <= col_size;
            r_row      <= '0;
            r_col      <= '0;
        end else if (en) begin
            if (w_row_wrap) begin
                r_row <= '0;
                r_col <= r_col + c_col_one;
            end else begin
                r_row <= r_row + c_row_one;
            end
        end
    end

    assign row        = r_row;
    assign col        = r_col;
    assign last_input = w_row_wrap && (r_col == r_col_size - c_col_one);
    // The frame ends two slots into the second flush line.
    assign last_slot  = (r_row == c_row_one) && (r_col == r_col_size + c_col_one);

endmodule

`default_nettype wire

// File: rtl/linebuf_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module  : linebuf_scan_ctrl
// Brief   : Frame sequencer feeding the 3x3 line buffer: pixel handshake,
//           bottom zero-flush, window count, errors. Optional perf counters
//           under LBCTRL_PERF_CNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module linebuf_scan_ctrl
    import lbctrl_pkg::*;
#(
    parameter int DataWidth   = 64,
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int WinCntWidth = 18
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [MaxRowWidth-1:0] row_in,
    input  logic [MaxColWidth-1:0] col_in,
    input  logic [DataWidth-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DataWidth-1:0]   lb_data,
    output logic [MaxRowWidth-1:0] lb_row_count,
    output logic [MaxColWidth-1:0] lb_col_count,
    input  logic                   lb_window_valid,
    output logic                   busy,
    output logic                   done,
    output logic [WinCntWidth-1:0] win_count,
    output logic                   err_cfg,
    output logic                   err_underrun
`ifdef LBCTRL_PERF_CNT_EN
    ,
    output logic [31:0]            cyc_count,
    output logic [15:0]            underrun_count
`endif
);

    lbctrl_state_t          r_state;
    logic [DataWidth-1:0]   r_lb_data;
    logic [MaxRowWidth-1:0] r_lb_row;
    logic [MaxColWidth-1:0] r_lb_col;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_done;
    logic [WinCntWidth-1:0] r_win_count;
    logic                   r_err_cfg;
    logic                   r_err_underrun;

    logic [MaxRowWidth-1:0] w_row;
    logic [MaxColWidth-1:0] w_col;
    logic                   w_last_input;
    logic                   w_last_slot;
    logic                   w_size_ok;
    logic                   w_start_ok;
    logic                   w_slot_en;
    logic                   w_scan_phase;

    assign w_size_ok    = size_ok(32'(row_in), 32'(col_in));
    assign w_start_ok   = (r_state == IDLE) && start && w_size_ok;
    // RUN and FLUSH register a slot every cycle; ARM only on the first handshake.
    assign w_slot_en    = ((r_state == ARM) && in_valid) || (r_state == RUN) || (r_state == FLUSH);
    assign w_scan_phase = (r_state == RUN) || (r_state == FLUSH) || (r_state == DONE);

    lbctrl_scan_cnt #(
        .MaxRowWidth (MaxRowWidth),
        .MaxColWidth (MaxColWidth)
    ) u_scan_cnt (
        .Clk        (Clk),
        .Rst        (Rst),
        .load       (w_start_ok),
        .en         (w_slot_en),
        .row_size   (row_in),
        .col_size   (col_in),
        .row        (w_row),
        .col        (w_col),
        .last_input (w_last_input),
        .last_slot  (w_last_slot)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= IDLE;
            r_lb_data      <= '0;
            r_lb_row       <= '0;
            r_lb_col       <= '0;
            r_in_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_cfg      <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_size_ok) begin
                            r_state        <= ARM;
                            r_in_ready     <= 1'b1;
                            r_busy         <= 1'b1;
                            r_err_cfg      <= 1'b0;
                            r_err_underrun <= 1'b0;
                        end else begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (in_valid) begin
                        r_lb_data <= in_data;
                        r_lb_row  <= w_row;
                        r_lb_col  <= w_col;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    // The line buffer cannot stall: a missing pixel becomes a zero slot.
                    r_lb_data <= in_valid ? in_data : '0;
                    r_lb_row  <= w_row;
                    r_lb_col  <= w_col;
                    if (!in_valid) begin
                        r_err_underrun <= 1'b1;
                    end
                    if (w_last_input) begin
                        r_state    <= FLUSH;
                        r_in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    r_lb_data <= '0;
                    r_lb_row  <= w_row;
                    r_lb_col  <= w_col;
                    if (w_last_slot) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_lb_data <= '0;
                    r_lb_row  <= '0;
                    r_lb_col  <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_win_count <= '0;
        end else if (w_start_ok) begin
            r_win_count <= '0;
        end else if (w_scan_phase && lb_window_valid) begin
            r_win_count <= r_win_count + WinCntWidth'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign lb_data      = r_lb_data;
    assign lb_row_count = r_lb_row;
    assign lb_col_count = r_lb_col;
    assign busy         = r_busy;
    assign done         = r_done;
    assign win_count    = r_win_count;
    assign err_cfg      = r_err_cfg;
    assign err_underrun = r_err_underrun;

`ifdef LBCTRL_PERF_CNT_EN
    logic [31:0] r_cyc_count;
    logic [15:0] r_underrun_count;

    // Starts at 2 so the start cycle and the done cycle are both included.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cyc_count      <= '0;
            r_underrun_count <= '0;
        end else if (w_start_ok) begin
            r_cyc_count      <= 32'd2;
            r_underrun_count <= '0;
        end else begin
            if ((r_state == ARM) || (r_state == RUN) || (r_state == FLUSH)) begin
                r_cyc_count <= r_cyc_count + 32'd1;
            end
            if ((r_state == RUN) && !in_valid && (r_underrun_count != 16'hFFFF)) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

    assign cyc_count      = r_cyc_count;
    assign underrun_count = r_underrun_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_linebuf_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_linebuf_scan_ctrl
// Brief   : Scoreboard bench for linebuf_scan_ctrl (slot order, data, flush,
//           done, window count, errors, reset abort).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_linebuf_scan_ctrl;

    localparam int DW = 64;
    localparam int RW = 9;
    localparam int CW = 9;
    localparam int WW = 18;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [RW-1:0] row_in;
    logic [CW-1:0] col_in;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] lb_data;
    logic [RW-1:0] lb_row_count;
    logic [CW-1:0] lb_col_count;
    logic          lb_window_valid;
    logic          busy;
    logic          done;
    logic [WW-1:0] win_count;
    logic          err_cfg;
    logic          err_underrun;
`ifdef LBCTRL_PERF_CNT_EN
    logic [31:0]   cyc_count;
    logic [15:0]   underrun_count;
`endif

    always #5 Clk = ~Clk;

    linebuf_scan_ctrl #(
        .DataWidth   (DW),
        .MaxRowWidth (RW),
        .MaxColWidth (CW),
        .WinCntWidth (WW)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .start           (start),
        .row_in          (row_in),
        .col_in          (col_in),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .lb_data         (lb_data),
        .lb_row_count    (lb_row_count),
        .lb_col_count    (lb_col_count),
        .lb_window_valid (lb_window_valid),
        .busy            (busy),
        .done            (done),
        .win_count       (win_count),
        .err_cfg         (err_cfg),
        .err_underrun    (err_underrun)
`ifdef LBCTRL_PERF_CNT_EN
        ,
        .cyc_count       (cyc_count),
        .underrun_count  (underrun_count)
`endif
    );

    typedef struct {
        logic [63:0] data;
        int          r;
        int          c;
        bit          last;
    } slot_t;

    slot_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_win, input bit exp_cfg, input bit exp_und);
        chk({tag, "_lb"}, 128'({lb_data, lb_row_count, lb_col_count}), 128'(0));
        chk({tag, "_ctl"}, 128'({in_ready, busy, done}), 128'(0));
        chk({tag, "_win"}, 128'(win_count), 128'(exp_win));
        chk({tag, "_err"}, 128'({err_cfg, err_underrun}), 128'({exp_cfg, exp_und}));
    endtask

    task automatic bad_start(input int rows, input int cols, input int held_win);
        @(posedge Clk); #1;
        start  = 1'b1;
        row_in = RW'(rows);
        col_in = CW'(cols);
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        chk("badcfg_state", 128'({err_cfg, in_ready, busy, done}), 128'(4'b1000));
        chk("badcfg_win_held", 128'(win_count), 128'(held_win));
    endtask

    // gr/gc: input slot driven with in_valid low (-1 for none); arm_wait: idle
    // cycles before the first pixel; abort: Rst while slot (2,1) is shown;
    // poke: start + new size while running.
    task automatic run_frame(input int rows, input int cols, input int gr, input int gc,
                             input int arm_wait, input bit abort, input bit poke);
        int    nr = 0;
        int    nc = 0;
        int    waitc = arm_wait;
        int    cyc = 0;
        int    budget;
        int    und_cnt = 0;
        bit    started = 0;
        bit    slots_done = 0;
        bit    finished = 0;
        bit    aborting = 0;
        bit    exp_und = 0;
        bit    shown;
        slot_t s;
        slot_t e;

        exp_q.delete();
        @(posedge Clk); #1;
        start           = 1'b1;
        row_in          = RW'(rows);
        col_in          = CW'(cols);
        in_valid        = 1'b0;
        lb_window_valid = 1'b0;
        @(posedge Clk); #1;
        budget = rows * (cols + 2) + arm_wait + 10;

        while (!finished && !aborting && cyc < budget) begin
            start    = 1'b0;
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            if (nc < cols) begin
                if (!started && waitc > 0) waitc--;
                else in_valid = !(nr == gr && nc == gc);
            end
            shown = (exp_q.size() > 0);
            if (shown) begin
                e = exp_q[0];
                // One window per input pixel, with one of them arriving in the done cycle.
                lb_window_valid = (e.c >= 1 && e.c <= cols && !(e.r == 0 && e.c == 1)) || e.last;
                if (abort && e.r == 2 && e.c == 1) begin
                    Rst      = 1'b1;
                    aborting = 1;
                end
            end else begin
                lb_window_valid = 1'b1;
            end
            if (poke && started && nr == 2 && nc == 1) begin
                start  = 1'b1;
                row_in = RW'(5);
                col_in = CW'(3);
            end

            @(negedge Clk);
            if (shown) begin
                e = exp_q.pop_front();
                chk("lb_data", 128'(lb_data), 128'(e.data));
                chk("lb_pos_done", 128'({lb_row_count, lb_col_count, done}),
                    128'({RW'(e.r), CW'(e.c), e.last}));
                if (e.last) finished = 1;
            end else begin
                chk("arm_outputs", 128'({lb_data, lb_row_count, lb_col_count, done}), 128'(0));
            end
            chk("ready_busy", 128'({in_ready, busy}), 128'({(nc < cols), 1'b1}));

            if (!aborting && !slots_done && (started || in_valid)) begin
                s.r    = nr;
                s.c    = nc;
                s.data = (nc < cols && in_valid) ? in_data : 64'd0;
                s.last = (nr == 1 && nc == cols + 1);
                if (nc < cols && !in_valid) begin
                    exp_und = 1;
                    und_cnt++;
                end
                exp_q.push_back(s);
                started = 1;
                if (s.last) slots_done = 1;
                if (nr == rows - 1) begin
                    nr = 0;
                    nc++;
                end else begin
                    nr++;
                end
            end
            cyc++;
            if (!finished && !aborting) begin
                @(posedge Clk); #1;
            end
        end

        if (aborting) begin
            @(posedge Clk); #1;
            Rst             = 1'b0;
            lb_window_valid = 1'b0;
            in_valid        = 1'b0;
            @(negedge Clk);
            chk_idle("abort", 0, 0, 0);
        end else if (!finished) begin
            chk("frame_timeout", 128'(cyc), 128'(budget + 1));
        end else begin
            @(posedge Clk); #1;
            in_valid        = 1'b1;
            lb_window_valid = 1'b1;
            @(negedge Clk);
            chk_idle("post", rows * cols, 0, exp_und);
`ifdef LBCTRL_PERF_CNT_EN
            chk("cyc_count", 128'(cyc_count), 128'(rows * (cols + 1) + 2 + arm_wait + 2));
            chk("underrun_count", 128'(underrun_count), 128'(und_cnt));
`endif
            @(posedge Clk); #1;
            in_valid        = 1'b0;
            lb_window_valid = 1'b0;
        end
        exp_q.delete();
    endtask

    initial begin
        Rst             = 1'b1;
        start           = 1'b0;
        row_in          = '0;
        col_in          = '0;
        in_data         = '0;
        in_valid        = 1'b0;
        lb_window_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        in_valid        = 1'b1;
        lb_window_valid = 1'b1;
        @(negedge Clk);
        chk_idle("reset", 0, 0, 0);
`ifdef LBCTRL_PERF_CNT_EN
        chk("reset_perf", 128'({cyc_count, underrun_count}), 128'(0));
`endif
        @(posedge Clk); #1;
        Rst             = 1'b0;
        in_valid        = 1'b0;
        lb_window_valid = 1'b0;

        run_frame(6, 4, -1, -1, 0, 0, 0);
        run_frame(6, 4, 3, 2, 0, 0, 0);
        bad_start(3, 4, 24);
        bad_start(6, 417, 24);
        bad_start(417, 4, 24);
        bad_start(6, 1, 24);
        run_frame(8, 8, -1, -1, 2, 0, 0);
        run_frame(6, 4, -1, -1, 0, 1, 0);
        run_frame(6, 4, -1, -1, 0, 0, 0);
        run_frame(6, 4, -1, -1, 1, 0, 1);
        run_frame(4, 2, 2, 1, 0, 0, 0);
        run_frame(4, 416, -1, -1, 0, 0, 0);
        run_frame(416, 100, 100, 50, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
